// File: rtl/sdram_burst_arbiter_if.sv
// Bus between the burst arbiter and its neighbours: FIFO levels, frame
// address windows, SDRAM controller handshake and the resulting burst pointers.
interface sdram_burst_arbiter_if #(
  parameter int CNT_W  = 11,
  parameter int ADDR_W = 22
);
  logic              sdram_init_done;
  logic [CNT_W-1:0]  wr_usedw;
  logic [CNT_W-1:0]  rd_usedw;
  logic              rd_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_max_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_max_addr;
  logic              wr_load;
  logic              rd_load;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic              burst_done;
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sys_wraddr;
  logic [ADDR_W-1:0] sys_rdaddr;
  logic              frame_write_done;
  logic              frame_read_done;
  logic              busy;

  // Arbiter side: consumes levels/handshakes, drives requests and pointers.
  modport master (
    input  sdram_init_done, wr_usedw, rd_usedw, rd_enable,
    input  wr_addr, wr_max_addr, rd_addr, rd_max_addr,
    input  wr_load, rd_load, sdram_wr_ack, sdram_rd_ack, burst_done,
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
    output frame_write_done, frame_read_done, busy
  );

  modport slave (
    output sdram_init_done, wr_usedw, rd_usedw, rd_enable,
    output wr_addr, wr_max_addr, rd_addr, rd_max_addr,
    output wr_load, rd_load, sdram_wr_ack, sdram_rd_ack, burst_done,
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
    input  frame_write_done, frame_read_done, busy
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Round-robin scheduler of SDRAM bursts between the camera write FIFO and the
// display read FIFO, with per-direction frame pointers and wrap reporting.
module sdram_burst_arbiter #(
  parameter int BURST_LEN  = 256,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 11,
  parameter int ADDR_W     = 22
) (
  input  logic                  clk_ref,
  input  logic                  rst_n,
  sdram_burst_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BURST,
    RD_REQ,
    RD_BURST
  } state_e;

  state_e            state;
  state_e            state_next;
  logic              last_grant_rd;
  logic              wr_elig;
  logic              rd_elig;
  logic              wr_complete;
  logic              rd_complete;
  logic              wr_in_use;
  logic              rd_in_use;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_next_ptr;
  logic [ADDR_W-1:0] rd_next_ptr;
  logic              wr_wrap;
  logic              rd_wrap;
  logic              wr_load_pend;
  logic              rd_load_pend;
  logic              wr_req_q;
  logic              rd_req_q;
  logic              busy_q;
  logic              wr_frame_q;
  logic              rd_frame_q;

  // Read eligibility is expressed as a fill limit to avoid unsigned underflow.
  always_comb begin
    wr_elig = bus.sdram_init_done && (bus.wr_usedw >= CNT_W'(BURST_LEN));
    rd_elig = bus.sdram_init_done && bus.rd_enable &&
              (bus.rd_usedw <= CNT_W'(FIFO_DEPTH - BURST_LEN));
    wr_in_use   = (state == WR_REQ) || (state == WR_BURST);
    rd_in_use   = (state == RD_REQ) || (state == RD_BURST);
    wr_complete = (state == WR_BURST) && bus.burst_done;
    rd_complete = (state == RD_BURST) && bus.burst_done;
    wr_next_ptr = wr_ptr + ADDR_W'(BURST_LEN);
    rd_next_ptr = rd_ptr + ADDR_W'(BURST_LEN);
    wr_wrap     = wr_next_ptr >= bus.wr_max_addr;
    rd_wrap     = rd_next_ptr >= bus.rd_max_addr;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_elig && rd_elig) state_next = last_grant_rd ? WR_REQ : RD_REQ;
        else if (wr_elig)       state_next = WR_REQ;
        else if (rd_elig)       state_next = RD_REQ;
      end
      WR_REQ:   if (bus.sdram_wr_ack) state_next = WR_BURST;
      WR_BURST: if (bus.burst_done)   state_next = IDLE;
      RD_REQ:   if (bus.sdram_rd_ack) state_next = RD_BURST;
      RD_BURST: if (bus.burst_done)   state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Requests and busy are registered decodes of the next state.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant_rd <= 1'b0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state    <= state_next;
      wr_req_q <= (state_next == WR_REQ);
      rd_req_q <= (state_next == RD_REQ);
      busy_q   <= (state_next != IDLE);
      if (wr_complete)      last_grant_rd <= 1'b0;
      else if (rd_complete) last_grant_rd <= 1'b1;
    end
  end

  // A load that lands on the completion edge counts as pending.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      wr_load_pend <= 1'b0;
      wr_frame_q   <= 1'b0;
    end else begin
      wr_frame_q <= 1'b0;
      if (wr_complete) begin
        wr_load_pend <= 1'b0;
        if (wr_load_pend || bus.wr_load) begin
          wr_ptr <= bus.wr_addr;
        end else if (wr_wrap) begin
          wr_ptr     <= bus.wr_addr;
          wr_frame_q <= 1'b1;
        end else begin
          wr_ptr <= wr_next_ptr;
        end
      end else if (bus.wr_load) begin
        if (wr_in_use) wr_load_pend <= 1'b1;
        else           wr_ptr       <= bus.wr_addr;
      end
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      rd_load_pend <= 1'b0;
      rd_frame_q   <= 1'b0;
    end else begin
      rd_frame_q <= 1'b0;
      if (rd_complete) begin
        rd_load_pend <= 1'b0;
        if (rd_load_pend || bus.rd_load) begin
          rd_ptr <= bus.rd_addr;
        end else if (rd_wrap) begin
          rd_ptr     <= bus.rd_addr;
          rd_frame_q <= 1'b1;
        end else begin
          rd_ptr <= rd_next_ptr;
        end
      end else if (bus.rd_load) begin
        if (rd_in_use) rd_load_pend <= 1'b1;
        else           rd_ptr       <= bus.rd_addr;
      end
    end
  end

  assign bus.sdram_wr_req     = wr_req_q;
  assign bus.sdram_rd_req     = rd_req_q;
  assign bus.busy             = busy_q;
  assign bus.sys_wraddr       = wr_ptr;
  assign bus.sys_rdaddr       = rd_ptr;
  assign bus.frame_write_done = wr_frame_q;
  assign bus.frame_read_done  = rd_frame_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: handshake timing, round robin,
// frame wrap, deferred loads, eligibility limits, init gating and reset.
module tb_sdram_burst_arbiter;

  logic clk_ref = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   fwd_cycles = 0;
  int   fw_start;
  int   req_cycles;

  sdram_burst_arbiter_if #(.CNT_W(11), .ADDR_W(22)) bus ();

  sdram_burst_arbiter #(
    .BURST_LEN(256), .FIFO_DEPTH(1024), .CNT_W(11), .ADDR_W(22)
  ) dut (
    .clk_ref(clk_ref),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_ref = ~clk_ref;

  // Counts every cycle frame_write_done is seen high.
  always @(negedge clk_ref) begin
    if (bus.frame_write_done === 1'b1) fwd_cycles = fwd_cycles + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  // Waits (bounded) for a request, checks its direction, acks it at once and
  // finishes the burst; returns on the negedge after the completion edge.
  task automatic serve(input logic exp_rd, input string tag);
    int n = 0;
    while (bus.sdram_wr_req !== 1'b1 && bus.sdram_rd_req !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check_output({tag, " req_seen"}, 32'(n < 20), 32'd1);
    check_output({tag, " dir"}, {31'b0, bus.sdram_rd_req}, {31'b0, exp_rd});
    if (bus.sdram_rd_req === 1'b1) bus.sdram_rd_ack = 1'b1;
    else                           bus.sdram_wr_ack = 1'b1;
    step(1);
    bus.sdram_rd_ack = 1'b0;
    bus.sdram_wr_ack = 1'b0;
    step(1);
    bus.burst_done = 1'b1;
    step(1);
    bus.burst_done = 1'b0;
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.sdram_init_done  = 1'b1;
    bus.wr_usedw         = '0;
    bus.rd_usedw         = 11'd1024;
    bus.rd_enable        = 1'b0;
    bus.wr_addr          = '0;
    bus.wr_max_addr      = 22'h100000;
    bus.rd_addr          = '0;
    bus.rd_max_addr      = 22'h100000;
    bus.wr_load          = 1'b0;
    bus.rd_load          = 1'b0;
    bus.sdram_wr_ack     = 1'b0;
    bus.sdram_rd_ack     = 1'b0;
    bus.burst_done       = 1'b0;

    step(2);
    check_output("rst wr_req", {31'b0, bus.sdram_wr_req}, 32'd0);
    check_output("rst rd_req", {31'b0, bus.sdram_rd_req}, 32'd0);
    check_output("rst busy", {31'b0, bus.busy}, 32'd0);
    check_output("rst wraddr", 32'(bus.sys_wraddr), 32'd0);
    check_output("rst rdaddr", 32'(bus.sys_rdaddr), 32'd0);
    check_output("rst frame_wd", {31'b0, bus.frame_write_done}, 32'd0);
    check_output("rst frame_rd", {31'b0, bus.frame_read_done}, 32'd0);
    rst_n = 1'b1;
    step(1);

    $display("[TB] write only, ack after 3 cycles, done 260 cycles later");
    bus.wr_usedw = 11'd256;
    step(1);
    check_output("w1 wr_req rise", {31'b0, bus.sdram_wr_req}, 32'd1);
    check_output("w1 rd_req", {31'b0, bus.sdram_rd_req}, 32'd0);
    check_output("w1 busy", {31'b0, bus.busy}, 32'd1);
    step(2);
    check_output("w1 wr_req held", {31'b0, bus.sdram_wr_req}, 32'd1);
    bus.sdram_wr_ack = 1'b1;
    step(1);
    bus.sdram_wr_ack = 1'b0;
    bus.wr_usedw = '0;
    check_output("w1 wr_req drop", {31'b0, bus.sdram_wr_req}, 32'd0);
    check_output("w1 busy burst", {31'b0, bus.busy}, 32'd1);
    step(259);
    check_output("w1 wraddr mid", 32'(bus.sys_wraddr), 32'd0);
    bus.burst_done = 1'b1;
    step(1);
    bus.burst_done = 1'b0;
    check_output("w1 wraddr done", 32'(bus.sys_wraddr), 32'd256);
    check_output("w1 busy idle", {31'b0, bus.busy}, 32'd0);
    check_output("w1 frame_wd", {31'b0, bus.frame_write_done}, 32'd0);
    check_output("w1 rd_req none", {31'b0, bus.sdram_rd_req}, 32'd0);
    bus.burst_done = 1'b1;
    step(1);
    bus.burst_done = 1'b0;
    check_output("stray done wraddr", 32'(bus.sys_wraddr), 32'd256);
    check_output("stray done busy", {31'b0, bus.busy}, 32'd0);

    $display("[TB] round robin");
    bus.wr_usedw  = 11'd512;
    bus.rd_enable = 1'b1;
    bus.rd_usedw  = '0;
    serve(1'b1, "rr1");
    check_output("rr1 rdaddr", 32'(bus.sys_rdaddr), 32'd256);
    serve(1'b0, "rr2");
    check_output("rr2 wraddr", 32'(bus.sys_wraddr), 32'd512);
    serve(1'b1, "rr3");
    check_output("rr3 rdaddr", 32'(bus.sys_rdaddr), 32'd512);
    serve(1'b0, "rr4");
    check_output("rr4 wraddr", 32'(bus.sys_wraddr), 32'd768);

    $display("[TB] frame wrap over 2880 bursts");
    bus.rd_enable   = 1'b0;
    bus.wr_usedw    = '0;
    bus.wr_addr     = 22'h100000;
    bus.wr_max_addr = 22'h1B4000;
    bus.wr_load     = 1'b1;
    step(1);
    bus.wr_load = 1'b0;
    check_output("fw load idle", 32'(bus.sys_wraddr), 32'h100000);
    fw_start = fwd_cycles;
    bus.wr_usedw = 11'd256;
    for (int i = 0; i < 2879; i++) serve(1'b0, "fw");
    #1;
    check_output("fw penultimate ptr", 32'(bus.sys_wraddr), 32'h1B3F00);
    check_output("fw no early pulse", 32'(fwd_cycles - fw_start), 32'd0);
    serve(1'b0, "fw last");
    bus.wr_usedw = '0;
    #1;
    check_output("fw wrapped ptr", 32'(bus.sys_wraddr), 32'h100000);
    check_output("fw pulse now", {31'b0, bus.frame_write_done}, 32'd1);
    step(3);
    #1;
    check_output("fw pulse cycles", 32'(fwd_cycles - fw_start), 32'd1);

    $display("[TB] load during write burst");
    bus.wr_usedw = 11'd256;
    step(1);
    check_output("ld wr_req", {31'b0, bus.sdram_wr_req}, 32'd1);
    bus.sdram_wr_ack = 1'b1;
    step(1);
    bus.sdram_wr_ack = 1'b0;
    bus.wr_usedw = '0;
    bus.wr_addr  = 22'h200000;
    bus.wr_load  = 1'b1;
    step(1);
    bus.wr_load = 1'b0;
    check_output("ld ptr held", 32'(bus.sys_wraddr), 32'h100000);
    step(2);
    check_output("ld ptr still held", 32'(bus.sys_wraddr), 32'h100000);
    fw_start = fwd_cycles;
    bus.burst_done = 1'b1;
    step(1);
    bus.burst_done = 1'b0;
    #1;
    check_output("ld ptr loaded", 32'(bus.sys_wraddr), 32'h200000);
    check_output("ld no frame_wd", {31'b0, bus.frame_write_done}, 32'd0);
    check_output("ld no frame count", 32'(fwd_cycles - fw_start), 32'd0);
    bus.wr_max_addr = 22'h300000;

    $display("[TB] eligibility limits");
    bus.wr_usedw  = 11'd255;
    bus.rd_enable = 1'b1;
    bus.rd_usedw  = 11'd769;
    step(3);
    check_output("edge none wr", {31'b0, bus.sdram_wr_req}, 32'd0);
    check_output("edge none rd", {31'b0, bus.sdram_rd_req}, 32'd0);
    bus.rd_usedw = 11'd768;
    serve(1'b1, "rd_edge");
    bus.rd_usedw = 11'd769;
    check_output("rd_edge rdaddr", 32'(bus.sys_rdaddr), 32'd768);
    bus.wr_usedw = 11'd256;
    serve(1'b0, "wr_edge");
    bus.sdram_init_done = 1'b0;
    check_output("wr_edge wraddr", 32'(bus.sys_wraddr), 32'h200100);

    $display("[TB] init gating");
    bus.rd_usedw = '0;
    req_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.sdram_wr_req === 1'b1 || bus.sdram_rd_req === 1'b1) req_cycles++;
    end
    check_output("init gated reqs", 32'(req_cycles), 32'd0);
    bus.sdram_init_done = 1'b1;
    step(1);
    check_output("init rd_req", {31'b0, bus.sdram_rd_req}, 32'd1);
    check_output("init wr_req", {31'b0, bus.sdram_wr_req}, 32'd0);

    $display("[TB] reset while read requested");
    rst_n = 1'b0;
    #1;
    check_output("mid rst rd_req", {31'b0, bus.sdram_rd_req}, 32'd0);
    check_output("mid rst busy", {31'b0, bus.busy}, 32'd0);
    bus.sdram_init_done = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    check_output("post rst wraddr", 32'(bus.sys_wraddr), 32'd0);
    check_output("post rst rdaddr", 32'(bus.sys_rdaddr), 32'd0);
    check_output("post rst wr_req", {31'b0, bus.sdram_wr_req}, 32'd0);
    bus.sdram_init_done = 1'b1;
    step(1);
    check_output("post rst rd first", {31'b0, bus.sdram_rd_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Schedules 256-word SDRAM bursts between the camera write FIFO and the display read FIFO of the two-FIFO SDRAM subsystem. Watches both FIFO fill levels, issues one burst request at a time to the SDRAM command controller, and generates the running burst addresses inside the frame bank selected by the bank switcher. Also reports frame completion in each direction. Sits in the `clk_ref` domain between the dual-clock FIFOs, the SDRAM controller and the bank switch logic.

## Interface
- `BURST_LEN`, 256: words per burst. Also the address increment.
- `FIFO_DEPTH`, 1024: words per FIFO.
- `CNT_W`, 11: width of the FIFO fill counts.
- `ADDR_W`, 22: SDRAM word address width, `{bank[1:0], offset[19:0]}`.

Ports:
- `clk_ref` in 1: SDRAM controller clock. The only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sdram_init_done` in 1: no request is issued while this is low.
- `wr_usedw` in CNT_W: write FIFO words stored, synchronous to `clk_ref`.
- `rd_usedw` in CNT_W: read FIFO words stored, synchronous to `clk_ref`.
- `rd_enable` in 1: display frame active; reads are allowed.
- `wr_addr`, `wr_max_addr` in ADDR_W: write frame base address and end address (exclusive).
- `rd_addr`, `rd_max_addr` in ADDR_W: read frame base address and end address (exclusive).
- `wr_load`, `rd_load` in 1: one-cycle pulse; reload the pointer from its base address.
- `sdram_wr_ack`, `sdram_rd_ack` in 1: one-cycle pulse; the controller accepted the request.
- `burst_done` in 1: one-cycle pulse; the current burst has finished.
- `sdram_wr_req`, `sdram_rd_req` out 1: burst request, level, held until ack.
- `sys_wraddr`, `sys_rdaddr` out ADDR_W: start address of the current or next burst.
- `frame_write_done`, `frame_read_done` out 1: one-cycle pulse on pointer wrap.
- `busy` out 1: high in every state except IDLE.

## Operation
- Eligibility:
  - Write is eligible when `wr_usedw >= BURST_LEN`.
  - Read is eligible when `rd_enable` is high and `FIFO_DEPTH - rd_usedw >= BURST_LEN`.
  - Neither direction is eligible while `sdram_init_done` is low.
- State machine: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
  - IDLE → WR_REQ or RD_REQ when the corresponding direction is eligible.
  - If both are eligible, round-robin: grant the direction opposite to `last_grant`. `last_grant` resets to write, so the first contested grant goes to read.
  - WR_REQ: `sdram_wr_req` = 1. On `sdram_wr_ack` → WR_BURST and drop the request.
  - RD_REQ and RD_BURST behave identically using `sdram_rd_req` and `sdram_rd_ack`.
  - WR_BURST / RD_BURST: wait for `burst_done`, then → IDLE, update `last_grant`, and advance the pointer.
- Pointer advance (ADDR_W-bit arithmetic):
  - If `ptr + BURST_LEN >= max`, load `ptr <= base` and pulse the direction's `frame_*_done`.
  - Otherwise `ptr <= ptr + BURST_LEN`.
- Load handling:
  - `wr_load` while not in WR_REQ/WR_BURST sets `sys_wraddr <= wr_addr` on the next edge.
  - `wr_load` in WR_REQ/WR_BURST sets `wr_load_pend`. At `burst_done` the pointer takes `wr_addr` instead of advancing, no frame-done pulse is issued, and the pending flag clears.
  - `rd_load` behaves identically with `rd_load_pend`.
- `burst_done` or an ack arriving in a state that does not expect it is ignored.
- `wr_load` and `rd_load` are independent; both may apply in the same cycle.

## Timing
- Reset values:
  - All outputs 0.
  - `sys_wraddr` = `sys_rdaddr` = 0, pending flags 0, `last_grant` = write, state IDLE.
- Request latency: eligibility sampled in IDLE at edge N; the request is high from edge N+1. All outputs are registered.
- Request deassertion: the request is low in the cycle after the ack is sampled.
- An ack in the same cycle the request first rises is valid.
- Completion: `burst_done` sampled at edge M. At edge M+1 the state is IDLE, the pointer is updated, and `frame_*_done` is high for exactly that one cycle.
- Earliest next request is at edge M+2.
- Eligibility is not re-checked in REQ states; a request, once raised, is held until acked.
- `rst_n` low mid-burst: immediate return to reset values; the outstanding burst is abandoned.

## Test plan
- Write with read blocked: `wr_usedw` = 256, `rd_enable` = 0, ack 3 cycles after request, `burst_done` 260 cycles later → one write request; `sys_wraddr` 0→256; no read request.
- Round robin: both directions continuously eligible → grant sequence RD, WR, RD, WR. `sys_rdaddr` advances by 256 per read and `sys_wraddr` by 256 per write.
- Frame wrap: `wr_addr` = 0x100000, `wr_max_addr` = 0x100000+737280, 2880 write bursts → after the last burst `sys_wraddr` = 0x100000 and `frame_write_done` pulses exactly once, for one cycle.
- Load during burst: `wr_load` pulsed in WR_BURST with `wr_addr` = 0x200000 → `sys_wraddr` is unchanged until `burst_done`, then becomes 0x200000 with no `frame_write_done`.
- Init gating: `sdram_init_done` = 0 with both FIFOs eligible → no request for 100 cycles. Raising `sdram_init_done` → `sdram_rd_req` one cycle later.
- Reset mid-request: `rst_n` low while `sdram_rd_req` = 1 → request low immediately; all addresses 0 after release.
